// File: rtl/prog_encoder_loader.sv
// prog_encoder_loader: encodes (mnemonic, operand) pairs into 9-bit
// instruction words and writes them to consecutive instruction-memory
// addresses starting at a session base address.
module prog_encoder_loader #(
  parameter int unsigned T     = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [T-1:0] base_addr,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [4:0]   op_code,
  input  logic [7:0]   operand,
  input  logic         op_last,
  output logic         im_we,
  output logic [T-1:0] im_addr,
  output logic [8:0]   im_wdata,
  output logic [T-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code
);

  // Word counter is one bit wider than the address so a full-depth session
  // can still be compared against DEPTH.
  localparam int unsigned CW = T + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CODE  = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [T-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [T-1:0]  addr_q, addr_d;
  logic [8:0]    wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    ecode_q, ecode_d;

  logic [8:0]    enc_word;
  logic          bad_code;
  logic          bad_range;
  logic [1:0]    abort_code;
  logic          accept;
  logic          at_depth;

  logic [3:0]    fld_r;
  logic [2:0]    fld_s;
  logic          r_ok;
  logic          s_ok;
  logic          g_ok;

  assign op_ready = (state_q == ST_LOAD);
  assign accept   = op_valid & op_ready;
  assign at_depth = (cnt_q == CW'(DEPTH));

  assign fld_r = operand[3:0];
  assign fld_s = operand[2:0];
  assign r_ok  = (operand[7:4] == 4'd0);
  assign s_ok  = (operand[7:3] == 5'b00001);
  assign g_ok  = (operand[7:3] == 5'd0);

  // Mnemonic encoder: instruction word plus code/operand legality flags.
  always_comb begin
    enc_word  = 9'd0;
    bad_code  = 1'b0;
    bad_range = 1'b0;
    case (op_code)
      5'd0:  enc_word = {1'b1, operand};
      5'd1:  begin enc_word = {1'b0, 4'b0000, fld_r};       bad_range = !r_ok; end
      5'd2:  begin enc_word = {1'b0, 4'b0001, fld_r};       bad_range = !r_ok; end
      5'd3:  begin enc_word = {1'b0, 4'b0010, 1'b0, fld_s}; bad_range = !s_ok; end
      5'd4:  begin enc_word = {1'b0, 4'b0010, 1'b1, fld_s}; bad_range = !s_ok; end
      5'd5:  begin enc_word = {1'b0, 4'b0011, 1'b0, fld_s}; bad_range = !s_ok; end
      5'd6:  begin enc_word = {1'b0, 4'b0011, 1'b1, fld_s}; bad_range = !g_ok; end
      5'd7:  begin enc_word = {1'b0, 4'b0100, fld_r};       bad_range = !r_ok; end
      5'd8:  begin enc_word = {1'b0, 4'b0101, fld_r};       bad_range = !r_ok; end
      5'd9:  begin enc_word = {1'b0, 4'b0110, fld_r};       bad_range = !r_ok; end
      5'd10: begin enc_word = {1'b0, 4'b0111, fld_r};       bad_range = !r_ok; end
      5'd11: begin enc_word = {1'b0, 4'b1000, 1'b0, fld_s}; bad_range = !g_ok; end
      5'd12: begin enc_word = {1'b0, 4'b1000, 1'b1, fld_s}; bad_range = !g_ok; end
      5'd13: begin enc_word = {1'b0, 4'b1001, fld_r};       bad_range = !r_ok; end
      5'd14: begin enc_word = {1'b0, 4'b1010, fld_r};       bad_range = !r_ok; end
      5'd15: enc_word = {1'b0, 4'b1011, 4'b0000};
      5'd16: begin enc_word = {1'b0, 4'b1110, 1'b0, fld_s}; bad_range = !g_ok; end
      5'd17: begin enc_word = {1'b0, 4'b1110, 1'b1, fld_s}; bad_range = !g_ok; end
      5'd18: begin enc_word = {1'b0, 4'b1111, 1'b0, fld_s}; bad_range = !g_ok; end
      5'd19: begin enc_word = {1'b0, 4'b1111, 1'b1, fld_s}; bad_range = !g_ok; end
      default: bad_code = 1'b1;
    endcase
  end

  // Abort reason for the pair on the bus, highest priority first.
  always_comb begin
    abort_code = ERR_NONE;
    if (bad_code) begin
      abort_code = ERR_CODE;
    end else if (bad_range) begin
      abort_code = ERR_RANGE;
    end else if (at_depth) begin
      abort_code = ERR_OVF;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    ecode_d = ecode_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = base_addr;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ecode_d = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (abort_code != ERR_NONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            ecode_d = abort_code;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + T'(1);
            cnt_d   = cnt_q + CW'(1);
            if (op_last) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ecode_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ecode_q <= ecode_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = cnt_q[T-1:0];
  assign busy     = (state_q == ST_LOAD);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = ecode_q;

endmodule
